// File: rtl/slot_pkg.sv
// -----------------------------------------------------------------------------
// slot_pkg
// Shared types and constants for the 7-segment slot machine reel controller:
// FSM state encoding, per-reel step modes and the BCD step helper.
// -----------------------------------------------------------------------------
package slot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SPIN,
      ST_RESULT
   } state_t;

   // Step modes: +1, -1 and +3, all modulo 10
   typedef enum logic [1:0] {
      STEP_UP1,
      STEP_DOWN1,
      STEP_UP3
   } step_t;

   localparam int unsigned NUM_REELS = 3;
   localparam logic [3:0]  BCD_MAX   = 4'd9;

   // Fixed step mode of each reel position
   function automatic step_t reel_step(input int unsigned idx);
      case (idx)
         0:       return STEP_UP1;
         1:       return STEP_DOWN1;
         default: return STEP_UP3;
      endcase
   endfunction

   // Next BCD digit for a given step mode; result always stays in 0..9
   function automatic logic [3:0] bcd_next(input logic [3:0] v, input step_t s);
      logic [3:0] n;
      n = v;
      case (s)
         STEP_UP1:   n = (v >= BCD_MAX)         ? 4'd0    : v + 4'd1;
         STEP_DOWN1: n = (v == 4'd0)            ? BCD_MAX : v - 4'd1;
         STEP_UP3:   n = (v >= BCD_MAX - 4'd2)  ? v - 4'd7 : v + 4'd3;
         default:    n = 4'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/slot_reel.sv
// -----------------------------------------------------------------------------
// slot_reel
// One BCD (0..9) reel counter. Steps by the selected mode when enabled,
// asynchronously cleared to 0.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (reel -> 0)
//   i_mode  in  step mode (+1 / -1 / +3 modulo 10)
//   i_en    in  step enable for this cycle
//   o_bcd   out current reel digit (registered)
// -----------------------------------------------------------------------------
module slot_reel
   import slot_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  step_t      i_mode,
   input  logic       i_en,
   output logic [3:0] o_bcd
);

   logic [3:0] r_bcd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcd <= '0;
      end else if (i_en) begin
         r_bcd <= bcd_next(r_bcd, i_mode);
      end
   end

   assign o_bcd = r_bcd;

endmodule

// File: rtl/slot_reel_ctrl.sv
// -----------------------------------------------------------------------------
// slot_reel_ctrl
// Three-reel slot machine controller feeding per-digit BCD-to-7-segment
// decoders. START spins all reels, each STOP halts the next reel in order,
// and the final result is scored as jackpot (all equal) or pair (two equal).
// Optional feature (macro SLOT_JACKPOT_BLINK_EN): blink the display by
// toggling blank every BLINK_DIV cycles while a jackpot result is shown.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   btn_start, btn_stop   raw active-high buttons (asynchronous to clk)
//   bcd0..bcd2            reel digits 0..9
//   spinning[2:0]         bit i = reel i stepping
//   busy                  high while spinning
//   jackpot, pair         score, valid in RESULT
//   blank                 display blank request
// -----------------------------------------------------------------------------
module slot_reel_ctrl
   import slot_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 2500000,
   parameter int unsigned BLINK_DIV = 12500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_stop,
   output logic [3:0] bcd0,
   output logic [3:0] bcd1,
   output logic [3:0] bcd2,
   output logic [2:0] spinning,
   output logic       busy,
   output logic       jackpot,
   output logic       pair,
   output logic       blank
);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("CLK_DIV must be at least 2");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink_div
      $error("BLINK_DIV must be at least 1");
   end

   localparam int unsigned       DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

   state_t           r_state;
   logic [DIV_W-1:0] r_presc;
   logic [1:0]       r_idx;
   logic [2:0]       r_spinning;
   logic             r_busy;
   logic             r_jackpot;
   logic             r_pair;

   logic r_start_s1, r_start_s2, r_start_d, r_start_p;
   logic r_stop_s1,  r_stop_s2,  r_stop_d,  r_stop_p;

   logic       w_tick;
   logic [2:0] w_en;
   logic [3:0] w_bcd [NUM_REELS];
   logic       w_jackpot;
   logic       w_pair;

   assign w_tick = (r_state == ST_SPIN) && (r_presc == DIV_LAST);

   // A reel being stopped in the same cycle as a tick keeps its pre-tick value
   for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
      assign w_en[g] = w_tick && r_spinning[g] && !(r_stop_p && (r_idx == 2'(g)));

      slot_reel u_reel (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_mode (reel_step(g)),
         .i_en   (w_en[g]),
         .o_bcd  (w_bcd[g])
      );
   end

   // All reels are frozen on the RESULT entry edge, so scoring sees final values
   assign w_jackpot = (w_bcd[0] == w_bcd[1]) && (w_bcd[1] == w_bcd[2]);
   assign w_pair    = !w_jackpot && ((w_bcd[0] == w_bcd[1]) ||
                                     (w_bcd[1] == w_bcd[2]) ||
                                     (w_bcd[0] == w_bcd[2]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_s1 <= 1'b0;
         r_start_s2 <= 1'b0;
         r_start_d  <= 1'b0;
         r_start_p  <= 1'b0;
         r_stop_s1  <= 1'b0;
         r_stop_s2  <= 1'b0;
         r_stop_d   <= 1'b0;
         r_stop_p   <= 1'b0;
         r_state    <= ST_IDLE;
         r_presc    <= '0;
         r_idx      <= '0;
         r_spinning <= '0;
         r_busy     <= 1'b0;
         r_jackpot  <= 1'b0;
         r_pair     <= 1'b0;
      end else begin
         // 2-FF synchronizer, then registered rising-edge pulse
         r_start_s1 <= btn_start;
         r_start_s2 <= r_start_s1;
         r_start_d  <= r_start_s2;
         r_start_p  <= r_start_s2 && !r_start_d;
         r_stop_s1  <= btn_stop;
         r_stop_s2  <= r_stop_s1;
         r_stop_d   <= r_stop_s2;
         r_stop_p   <= r_stop_s2 && !r_stop_d;

         case (r_state)
            ST_SPIN: begin
               r_presc <= (r_presc == DIV_LAST) ? '0 : r_presc + 1'b1;
               if (r_stop_p) begin
                  r_spinning[r_idx] <= 1'b0;
                  if (r_idx == 2'(NUM_REELS - 1)) begin
                     r_state   <= ST_RESULT;
                     r_busy    <= 1'b0;
                     r_idx     <= '0;
                     r_presc   <= '0;
                     r_jackpot <= w_jackpot;
                     r_pair    <= w_pair;
                  end else begin
                     r_idx <= r_idx + 2'd1;
                  end
               end
            end
            ST_IDLE, ST_RESULT: begin
               r_presc <= '0;
               if (r_start_p) begin
                  r_state    <= ST_SPIN;
                  r_busy     <= 1'b1;
                  r_spinning <= '1;
                  r_idx      <= '0;
                  r_jackpot  <= 1'b0;
                  r_pair     <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_presc <= '0;
            end
         endcase
      end
   end

   assign bcd0     = w_bcd[0];
   assign bcd1     = w_bcd[1];
   assign bcd2     = w_bcd[2];
   assign spinning = r_spinning;
   assign busy     = r_busy;
   assign jackpot  = r_jackpot;
   assign pair     = r_pair;

`ifdef SLOT_JACKPOT_BLINK_EN
   localparam int unsigned      BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [BLK_W-1:0] r_blink_cnt;
   logic             r_blank;

   // Stops on the same edge RESULT is left so blank never lingers into SPIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_blank     <= 1'b0;
      end else if ((r_state == ST_RESULT) && r_jackpot && !r_start_p) begin
         if (r_blink_cnt == BLK_LAST) begin
            r_blink_cnt <= '0;
            r_blank     <= !r_blank;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end else begin
         r_blink_cnt <= '0;
         r_blank     <= 1'b0;
      end
   end

   assign blank = r_blank;
`else
   assign blank = 1'b0;
`endif

endmodule
